// File: rtl/qfix_pkg.sv
// Shared helpers for the sign-magnitude fixed-point family (add/sub, mul, div).
// Word layout: bit N-1 is the sign, bits N-2:0 are the magnitude.
package qfix_pkg;

  // Widest word the helpers operate on; callers zero-extend into this width.
  localparam int MAX_W = 64;

  // Position of the sign bit in an N-bit word.
  function automatic int sm_sign_bit(input int n);
    return n - 1;
  endfunction

  // Width of the magnitude field in an N-bit word.
  function automatic int sm_mag_w(input int n);
    return n - 1;
  endfunction

  // Max-magnitude word for width n: sign clear, all magnitude bits set.
  function automatic logic [MAX_W-1:0] sm_max(input int n);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < n - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Returns the sign to present, forcing zero magnitudes positive so -0 never escapes.
  function automatic logic sm_norm(input logic [MAX_W-1:0] mag, input logic sign);
    return sign && (mag != '0);
  endfunction

endpackage

// File: rtl/qaddsub_pipe_if.sv
// Operand/result handshake bundle for the sign-magnitude adder/subtractor.
interface qaddsub_pipe_if #(
  parameter int N     = 32,
  parameter int CNT_W = 8
);

  logic [N-1:0]     i_a;
  logic [N-1:0]     i_b;
  logic             i_sub;
  logic             i_valid;
  logic             o_ready;
  logic [N-1:0]     o_result;
  logic             o_ovf;
  logic             o_valid;
  logic             i_ready;
  logic [CNT_W-1:0] o_ovf_count;
  logic             i_clr_count;

  // Producer/consumer side that drives operands and accepts results.
  modport master (
    output i_a, i_b, i_sub, i_valid, i_ready, i_clr_count,
    input  o_ready, o_result, o_ovf, o_valid, o_ovf_count
  );

  // Arithmetic block side.
  modport slave (
    input  i_a, i_b, i_sub, i_valid, i_ready, i_clr_count,
    output o_ready, o_result, o_ovf, o_valid, o_ovf_count
  );

endinterface

// File: rtl/qmag_addsub.sv
// Magnitude-only add/subtract core. Sign handling, saturation and
// normalisation are left to the caller so mul/div rounding can reuse it.
module qmag_addsub #(
  parameter int MAG_W = 31
) (
  input  logic [MAG_W-1:0] ma_i,
  input  logic [MAG_W-1:0] mb_i,
  input  logic             eff_add_i,
  input  logic             a_ge_b_i,
  output logic [MAG_W-1:0] mag_o,
  output logic             sign_sel_o,
  output logic             ovf_o
);

  logic [MAG_W:0] sum;

  // Add magnitudes when signs agree, else subtract smaller from larger; sign_sel_o=1 picks A's sign.
  always_comb begin
    sum        = {1'b0, ma_i} + {1'b0, mb_i};
    mag_o      = '0;
    sign_sel_o = 1'b1;
    ovf_o      = 1'b0;
    if (eff_add_i) begin
      mag_o = sum[MAG_W-1:0];
      ovf_o = sum[MAG_W];
    end else if (a_ge_b_i) begin
      mag_o = ma_i - mb_i;
    end else begin
      mag_o      = mb_i - ma_i;
      sign_sel_o = 1'b0;
    end
  end

endmodule

// File: rtl/qaddsub_pipe.sv
// Two-stage pipelined sign-magnitude fixed-point adder/subtractor with
// valid/ready flow control, overflow flag, optional saturation and a
// saturating overflow event counter.
module qaddsub_pipe
  import qfix_pkg::*;
#(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int SAT   = 1,
  parameter int CNT_W = 8
) (
  input logic           i_clk,
  input logic           i_rst_n,
  qaddsub_pipe_if.slave bus
);

  localparam int SIGN_BIT = sm_sign_bit(N);
  localparam int MAG_W    = sm_mag_w(N);
  localparam logic [MAX_W-1:0] MAX_WORD = sm_max(N);
  localparam logic [MAG_W-1:0] SAT_MAG  = MAX_WORD[MAG_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Q only describes where the binary point sits; reject formats that cannot exist.
  if (N < 4 || N > MAX_W || Q < 0 || Q > N - 1) begin : g_param_check
    $error("qaddsub_pipe: unsupported N/Q combination");
  end

  // Flow control
  logic ready_en_q;
  logic s1_advance;
  logic in_ready;
  logic out_fire;

  // Stage 1: decoded operands
  logic             s1_valid_q;
  logic             s1_sa_q,      s1_sa_d;
  logic             s1_sb_q,      s1_sb_d;
  logic             s1_eff_add_q, s1_eff_add_d;
  logic             s1_ge_q,      s1_ge_d;
  logic [MAG_W-1:0] s1_ma_q,      s1_ma_d;
  logic [MAG_W-1:0] s1_mb_q,      s1_mb_d;

  // Stage 2: finished result
  logic             s2_valid_q;
  logic [N-1:0]     s2_result_q, s2_result_d;
  logic             s2_ovf_q,    s2_ovf_d;

  // Core outputs and post-processing
  logic [MAG_W-1:0] core_mag;
  logic             core_sign_sel;
  logic             core_ovf;
  logic [MAG_W-1:0] fin_mag;
  logic             raw_sign;

  // Overflow event counter
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stage 1 advances when stage 2 is empty or draining; o_ready stays low until the first edge out of reset.
  always_comb begin
    s1_advance = !s2_valid_q || bus.i_ready;
    in_ready   = ready_en_q && (!s1_valid_q || s1_advance);
    out_fire   = s2_valid_q && bus.i_ready;
  end

  // Ready enable: held low through reset, set on the first clock after release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) ready_en_q <= 1'b0;
    else          ready_en_q <= 1'b1;
  end

  // Operand decode: fold the subtract into B's sign and classify the operation.
  always_comb begin
    s1_sa_d      = bus.i_a[SIGN_BIT];
    s1_sb_d      = bus.i_b[SIGN_BIT] ^ bus.i_sub;
    s1_ma_d      = bus.i_a[MAG_W-1:0];
    s1_mb_d      = bus.i_b[MAG_W-1:0];
    s1_eff_add_d = (s1_sa_d == s1_sb_d);
    s1_ge_d      = (s1_ma_d >= s1_mb_d);
  end

  // Stage 1 register: capture operands only on an input transfer, otherwise hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sa_q      <= 1'b0;
      s1_sb_q      <= 1'b0;
      s1_eff_add_q <= 1'b0;
      s1_ge_q      <= 1'b0;
      s1_ma_q      <= '0;
      s1_mb_q      <= '0;
    end else if (in_ready) begin
      s1_valid_q <= bus.i_valid;
      if (bus.i_valid) begin
        s1_sa_q      <= s1_sa_d;
        s1_sb_q      <= s1_sb_d;
        s1_eff_add_q <= s1_eff_add_d;
        s1_ge_q      <= s1_ge_d;
        s1_ma_q      <= s1_ma_d;
        s1_mb_q      <= s1_mb_d;
      end
    end
  end

  qmag_addsub #(.MAG_W(MAG_W)) u_core (
    .ma_i       (s1_ma_q),
    .mb_i       (s1_mb_q),
    .eff_add_i  (s1_eff_add_q),
    .a_ge_b_i   (s1_ge_q),
    .mag_o      (core_mag),
    .sign_sel_o (core_sign_sel),
    .ovf_o      (core_ovf)
  );

  // Result assembly: choose sign, saturate or wrap on overflow, then normalise -0.
  always_comb begin
    raw_sign    = core_sign_sel ? s1_sa_q : s1_sb_q;
    fin_mag     = (core_ovf && (SAT != 0)) ? SAT_MAG : core_mag;
    s2_result_d = {sm_norm(MAX_W'(fin_mag), raw_sign), fin_mag};
    s2_ovf_d    = core_ovf;
  end

  // Stage 2 register: load when the pipe advances, hold result stable under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_ovf_q    <= 1'b0;
    end else if (s1_advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_result_q <= s2_result_d;
        s2_ovf_q    <= s2_ovf_d;
      end
    end
  end

  // Counter next state: clear wins, otherwise count overflowing output transfers up to the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.i_clr_count)                             cnt_d = '0;
    else if (out_fire && s2_ovf_q && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // Overflow counter register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bus.o_ready     = in_ready;
  assign bus.o_valid     = s2_valid_q;
  assign bus.o_result    = s2_result_q;
  assign bus.o_ovf       = s2_ovf_q;
  assign bus.o_ovf_count = cnt_q;

endmodule

// File: tb/tb_qaddsub_pipe.sv
// Self-checking bench for qaddsub_pipe: saturating and wrapping instances
// share one stimulus stream and are compared against an integer model.
module tb_qaddsub_pipe;

  localparam int N     = 32;
  localparam int Q     = 15;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
  } op_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qaddsub_pipe_if #(.N(N), .CNT_W(CNT_W)) ifm ();
  qaddsub_pipe_if #(.N(N), .CNT_W(CNT_W)) ifw ();

  assign ifw.i_a         = ifm.i_a;
  assign ifw.i_b         = ifm.i_b;
  assign ifw.i_sub       = ifm.i_sub;
  assign ifw.i_valid     = ifm.i_valid;
  assign ifw.i_ready     = ifm.i_ready;
  assign ifw.i_clr_count = ifm.i_clr_count;

  qaddsub_pipe #(.Q(Q), .N(N), .SAT(1), .CNT_W(CNT_W)) dutSat (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifm)
  );

  qaddsub_pipe #(.Q(Q), .N(N), .SAT(0), .CNT_W(CNT_W)) dutWrap (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifw)
  );

  int checks = 0;
  int errors = 0;
  int outCount = 0;
  int stallCycles = 0;
  int modelCnt = 0;
  op_t satQ[$];
  op_t wrapQ[$];

  // Model: signed integer arithmetic, then clamp/wrap to the magnitude range. Returns {ovf, result}.
  function automatic logic [32:0] refOp(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic sat);
    longint va, vb, r, mag, lim;
    logic neg, ovf;
    lim = 64'h7FFF_FFFF;
    va = longint'(a[30:0]);
    vb = longint'(b[30:0]);
    if (a[31]) va = -va;
    if (b[31]) vb = -vb;
    r   = sub ? (va - vb) : (va + vb);
    neg = (r < 0);
    mag = neg ? -r : r;
    ovf = (mag > lim);
    if (ovf) mag = sat ? lim : (mag % (lim + 1));
    if (mag == 0) neg = 1'b0;
    return {ovf, neg, mag[30:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one operation and hold it until the DUT accepts it (bounded).
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic sampled;
    logic done;
    done = 1'b0;
    ifm.i_a     = a;
    ifm.i_b     = b;
    ifm.i_sub   = sub;
    ifm.i_valid = 1'b1;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      sampled = ifm.o_ready;
      @(posedge clk);
      #1;
      if (sampled) done = 1'b1;
      else stallCycles++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no o_ready, expected acceptance of a=%h", a);
    end
  endtask

  task automatic idle();
    ifm.i_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every cycle, compare presented results with the model and track the counter.
  always @(negedge clk) begin
    logic [32:0] e;
    logic hit;
    op_t o;
    if (!rst_n) begin
      satQ.delete();
      wrapQ.delete();
      modelCnt = 0;
    end else begin
      hit = 1'b0;
      checkOutput("ovf_count", 64'(ifm.o_ovf_count), 64'(modelCnt));
      if (ifm.o_valid) begin
        if (satQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sat_spurious_valid: got o_valid=1, expected 0 (nothing in flight)");
        end else begin
          o = satQ[0];
          e = refOp(o.a, o.b, o.sub, 1'b1);
          checkOutput("sat_result", 64'(ifm.o_result), 64'(e[31:0]));
          checkOutput("sat_ovf", 64'(ifm.o_ovf), 64'(e[32]));
          if (ifm.i_ready) begin
            hit = e[32];
            void'(satQ.pop_front());
            outCount++;
          end
        end
      end
      if (ifw.o_valid) begin
        if (wrapQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL wrap_spurious_valid: got o_valid=1, expected 0 (nothing in flight)");
        end else begin
          o = wrapQ[0];
          e = refOp(o.a, o.b, o.sub, 1'b0);
          checkOutput("wrap_result", 64'(ifw.o_result), 64'(e[31:0]));
          checkOutput("wrap_ovf", 64'(ifw.o_ovf), 64'(e[32]));
          if (ifw.i_ready) void'(wrapQ.pop_front());
        end
      end
      if (ifm.i_clr_count) modelCnt = 0;
      else if (hit && modelCnt < CNT_MAX) modelCnt++;
      o.a = ifm.i_a;
      o.b = ifm.i_b;
      o.sub = ifm.i_sub;
      if (ifm.i_valid && ifm.o_ready) satQ.push_back(o);
      if (ifw.i_valid && ifw.o_ready) wrapQ.push_back(o);
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected completion before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int startOut;
    logic sampled;
    logic [31:0] ra;
    logic [31:0] rb;

    ifm.i_a = '0;
    ifm.i_b = '0;
    ifm.i_sub = 1'b0;
    ifm.i_valid = 1'b0;
    ifm.i_ready = 1'b1;
    ifm.i_clr_count = 1'b0;
    rst_n = 1'b0;

    $display("[TB] pinning reference model");
    checkOutput("ref_1m05",     64'(refOp(32'h0000_8000, 32'h0000_4000, 1'b1, 1'b1)), 64'h0_0000_4000);
    checkOutput("ref_05m1",     64'(refOp(32'h0000_4000, 32'h0000_8000, 1'b1, 1'b1)), 64'h0_8000_4000);
    checkOutput("ref_negzero",  64'(refOp(32'h8000_8000, 32'h0000_8000, 1'b0, 1'b1)), 64'h0_0000_0000);
    checkOutput("ref_ovf_sat",  64'(refOp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1)), 64'h1_7FFF_FFFF);
    checkOutput("ref_ovf_wrap", 64'(refOp(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0)), 64'h1_0000_0000);
    checkOutput("ref_ovf_neg",  64'(refOp(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1)), 64'h1_FFFF_FFFF);

    $display("[TB] reset state");
    waitCycles(2);
    checkOutput("rst_valid",  64'(ifm.o_valid), 64'd0);
    checkOutput("rst_result", 64'(ifm.o_result), 64'd0);
    checkOutput("rst_ovf",    64'(ifm.o_ovf), 64'd0);
    checkOutput("rst_count",  64'(ifm.o_ovf_count), 64'd0);
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("ready_after_reset", 64'(ifm.o_ready), 64'd1);

    $display("[TB] test 1: latency and basic subtract");
    applyStimulus(32'h0000_8000, 32'h0000_4000, 1'b1);
    idle();
    checkOutput("lat_not_yet", 64'(ifm.o_valid), 64'd0);
    waitCycles(1);
    checkOutput("lat_valid",  64'(ifm.o_valid), 64'd1);
    checkOutput("lat_result", 64'(ifm.o_result), 64'h0000_4000);
    checkOutput("lat_ovf",    64'(ifm.o_ovf), 64'd0);
    waitCycles(2);

    $display("[TB] test 2: sign selection and zero normalisation");
    applyStimulus(32'h0000_4000, 32'h0000_8000, 1'b1);
    applyStimulus(32'h8000_8000, 32'h0000_8000, 1'b0);
    idle();
    checkOutput("neg_result", 64'(ifm.o_result), 64'h8000_4000);
    waitCycles(1);
    checkOutput("zero_result", 64'(ifm.o_result), 64'h0000_0000);
    waitCycles(2);

    $display("[TB] test 3: overflow");
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    idle();
    waitCycles(1);
    checkOutput("ovf_sat_result",  64'(ifm.o_result), 64'h7FFF_FFFF);
    checkOutput("ovf_sat_flag",    64'(ifm.o_ovf), 64'd1);
    checkOutput("ovf_wrap_result", 64'(ifw.o_result), 64'h0000_0000);
    checkOutput("ovf_wrap_flag",   64'(ifw.o_ovf), 64'd1);
    checkOutput("ovf_count_before", 64'(ifm.o_ovf_count), 64'd0);
    waitCycles(1);
    checkOutput("ovf_count_after", 64'(ifm.o_ovf_count), 64'd1);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    idle();
    waitCycles(1);
    checkOutput("ovf_neg_result", 64'(ifm.o_result), 64'hFFFF_FFFF);
    checkOutput("ovf_neg_flag",   64'(ifm.o_ovf), 64'd1);
    waitCycles(2);

    $display("[TB] test 4: backpressure");
    startOut = outCount;
    ifm.i_ready = 1'b0;
    k = 1;
    for (int c = 0; c < 4; c++) begin
      ifm.i_a = 32'(k);
      ifm.i_b = '0;
      ifm.i_sub = 1'b0;
      ifm.i_valid = 1'b1;
      @(negedge clk);
      sampled = ifm.o_ready;
      @(posedge clk);
      #1;
      if (sampled) k++;
    end
    checkOutput("bp_accepts",     64'(k - 1), 64'd2);
    checkOutput("bp_ready_low",   64'(ifm.o_ready), 64'd0);
    checkOutput("bp_held_result", 64'(ifm.o_result), 64'd1);
    ifm.i_ready = 1'b1;
    for (int t = 0; t < 20 && k < 5; t++) begin
      ifm.i_a = 32'(k);
      @(negedge clk);
      sampled = ifm.o_ready;
      @(posedge clk);
      #1;
      if (sampled) k++;
    end
    idle();
    checkOutput("bp_all_accepted", 64'(k), 64'd5);
    waitCycles(4);
    checkOutput("bp_out_count", 64'(outCount - startOut), 64'd4);
    checkOutput("bp_drained",   64'(satQ.size()), 64'd0);

    $display("[TB] test 5: 100 back-to-back random operations");
    startOut = outCount;
    stallCycles = 0;
    for (int i = 0; i < 100; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 4 == 0) rb[31] = ra[31];
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
    end
    idle();
    waitCycles(3);
    checkOutput("stream_out_count", 64'(outCount - startOut), 64'd100);
    checkOutput("stream_stalls",    64'(stallCycles), 64'd0);

    $display("[TB] test 6: reset with both stages full");
    ifm.i_ready = 1'b0;
    applyStimulus(32'h0000_0100, 32'h0000_0001, 1'b0);
    applyStimulus(32'h0000_0200, 32'h0000_0001, 1'b0);
    idle();
    checkOutput("full_ready_low", 64'(ifm.o_ready), 64'd0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_valid", 64'(ifm.o_valid), 64'd0);
    checkOutput("async_rst_count", 64'(ifm.o_ovf_count), 64'd0);
    checkOutput("async_rst_wrap_valid", 64'(ifw.o_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifm.i_ready = 1'b1;
    waitCycles(1);
    checkOutput("post_rst_ready", 64'(ifm.o_ready), 64'd1);
    applyStimulus(32'h0000_8000, 32'h0000_8000, 1'b0);
    idle();
    checkOutput("post_rst_not_yet", 64'(ifm.o_valid), 64'd0);
    waitCycles(1);
    checkOutput("post_rst_valid",  64'(ifm.o_valid), 64'd1);
    checkOutput("post_rst_result", 64'(ifm.o_result), 64'h0001_0000);
    waitCycles(2);

    $display("[TB] clear has priority over an overflow transfer");
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    idle();
    waitCycles(1);
    checkOutput("clr_ovf_present", 64'(ifm.o_ovf), 64'd1);
    ifm.i_clr_count = 1'b1;
    waitCycles(1);
    ifm.i_clr_count = 1'b0;
    checkOutput("clr_priority", 64'(ifm.o_ovf_count), 64'd0);
    waitCycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qaddsub_pipe.md
Name: qaddsub_pipe

Overview:
- Pipelined sign-magnitude fixed-point adder/subtractor with a per-operation mode select (add or subtract).
- Parametrised in width and fraction bits; adds overflow detection, optional saturation, negative-zero normalisation and a sticky overflow counter.
- Sits alongside the sibling fixed-point multiplier and divider and uses the same Q-format: bit N-1 is the sign, bits N-2:0 are the magnitude, and the low Q bits are the fraction.
- Uses a valid/ready handshake so it can be chained directly in datapath pipelines.

Parameters:
- Q, 15, fraction bits; informational only, because magnitude arithmetic is format-agnostic.
- N, 32, total word width including the sign bit; N >= 4.
- SAT, 1, 1 = saturate to max magnitude on overflow; 0 = wrap, i.e. keep the low N-1 magnitude bits.
- CNT_W, 8, width of the overflow event counter.

Ports:
- i_clk  in  1  clock; all logic is rising-edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_a  in  N  operand A, sign-magnitude.
- i_b  in  N  operand B, sign-magnitude.
- i_sub  in  1  0 = A+B, 1 = A-B.
- i_valid  in  1  operands valid.
- o_ready  out  1  block can accept operands this cycle.
- o_result  out  N  result, sign-magnitude.
- o_ovf  out  1  overflow flag for the result currently presented.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts the result.
- o_ovf_count  out  CNT_W  saturating count of accepted results with o_ovf=1.
- i_clr_count  in  1  synchronous clear of o_ovf_count.

Behaviour:
- Reset: on i_rst_n low, asynchronously and immediately, all of the following go to 0: o_valid, o_result, o_ovf, o_ovf_count, and both stage-valid bits. o_ready is 1 one cycle after deassertion. Any in-flight operations are discarded.
- Handshake: transfer in when i_valid && o_ready; transfer out when o_valid && i_ready.
  - o_ready = !s1_valid || s1_advance.
  - s1_advance = !s2_valid || i_ready.
  - Full throughput is 1 op/cycle.
  - Latency is exactly 2 cycles from the input transfer to o_valid, with no stall.
- Stage 1 registers:
  - effective B sign sb' = b[N-1] ^ i_sub.
  - eff_add = (a[N-1] == sb').
  - magnitudes ma, mb, and a_ge_b = (ma >= mb).
  - sign_a.
- Stage 2 computes the result and registers it:
  - eff_add: sum = ma + mb (N bits wide); sign = sign_a; ovf = sum[N-1].
  - Otherwise: mag = a_ge_b ? ma - mb : mb - ma; sign = a_ge_b ? sign_a : sb'; ovf = 0.
  - On ovf with SAT=1: magnitude = all ones (N-1 bits), sign kept.
  - On ovf with SAT=0: magnitude = sum[N-2:0].
  - Normalisation: if the final magnitude is 0, the sign is forced to 0, so -0 is never output. Negative-zero inputs are treated as zero.
- Stall: while o_valid && !i_ready, stage 2 holds o_result and o_ovf stable. Stage 1 holds if it is occupied. o_ready falls only when both stages are full.
- o_ovf_count:
  - Increments when an output transfer occurs with o_ovf=1.
  - Saturates at 2^CNT_W-1.
  - i_clr_count has priority over the increment in the same cycle.
- Simultaneous input and output transfer in the same cycle: both take effect; the pipeline stays full with no bubble.
- Inputs are sampled only on transfer. Changing i_a or i_b while o_ready=0 has no effect.

Decomposition:
- Package qfix_pkg:
  - localparam helpers for sign/magnitude slicing: SIGN_BIT = N-1, MAG_W = N-1.
  - Function sm_max(N), returning the max-magnitude word.
  - Function sm_norm, which clears the sign of zero magnitudes.
- One combinational sub-module, qmag_addsub:
  - Inputs: ma, mb, eff_add, a_ge_b.
  - Outputs: magnitude, sign-select, ovf.
  - Instantiated in stage 2 and reusable by the multiplier and divider rounding paths.

Test Plan (N=32, Q=15, SAT=1 unless stated; 1.0 = 0x00008000):
1. Sub, +1.0 - +0.5: a=0x00008000, b=0x00004000, i_sub=1 -> o_result=0x00004000, o_ovf=0, o_valid exactly 2 cycles after transfer.
2. Sub, +0.5 - +1.0: a=0x00004000, b=0x00008000, i_sub=1 -> 0x80004000. Add, -1.0 + +1.0: a=0x80008000, b=0x00008000, i_sub=0 -> 0x00000000, no -0.
3. Overflow: a=0x7FFFFFFF, b=0x00000001, i_sub=0.
   - SAT=1 -> 0x7FFFFFFF, o_ovf=1, o_ovf_count 0->1.
   - SAT=0 -> 0x00000000, o_ovf=1.
   - a=0xFFFFFFFF, b=0x00000001, i_sub=1, SAT=1 -> 0xFFFFFFFF, o_ovf=1.
4. Backpressure: i_valid held high with ops 1, 2, 3, 4 and i_ready=0 for 4 cycles -> o_ready=0 after 2 accepts, o_result held stable. After i_ready=1, results emerge in order at 1 per cycle with none lost or duplicated.
5. Back-to-back streaming: 100 random operations with i_ready=1 -> 100 results, matched against a sign-magnitude reference model, no bubbles.
6. Reset mid-operation: assert i_rst_n low with both stages full -> o_valid and o_ovf_count drop to 0 asynchronously. After release, the first new op completes in 2 cycles. Also check: i_clr_count and an overflow transfer in the same cycle -> count = 0.
